// File: rtl/fp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_sequencer
// Purpose  : Operand FIFO and issue controller for fp_adder. Predicts the
//            adder latency per operation and captures its sum/error.
// Revision : 1.0  initial release
// ============================================================================
module fp_add_sequencer #(
    parameter int DEPTH    = 4,
    parameter int LAT_NORM = 4,
    parameter int LAT_EXC  = 2,
    parameter int ERRW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    output logic [31:0]     add_a,
    output logic [31:0]     add_b,
    output logic            add_valid,
    input  logic [31:0]     add_sum,
    input  logic            add_error,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_sum,
    output logic            out_error,
    output logic            busy,
    output logic [ERRW-1:0] err_cnt
);

    localparam int c_aw      = $clog2(DEPTH);
    localparam int c_lat_max = (LAT_NORM > LAT_EXC) ? LAT_NORM : LAT_EXC;
    localparam int c_cw      = $clog2(c_lat_max + 1);
    localparam logic [c_cw-1:0] c_cnt_norm = c_cw'(LAT_NORM - 1);
    localparam logic [c_cw-1:0] c_cnt_exc  = c_cw'(LAT_EXC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [63:0]     r_mem [DEPTH];
    logic [c_aw:0]   r_wr_ptr;
    logic [c_aw:0]   r_rd_ptr;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic [c_cw-1:0] r_cnt;
    logic            r_add_valid;
    logic            r_out_valid;
    logic [31:0]     r_out_sum;
    logic            r_out_error;
    logic [ERRW-1:0] r_err_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_exc;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !r_out_valid;
    assign w_exc   = (r_op_a[30:23] == 8'hFF) || (r_op_b[30:23] == 8'hFF);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // r_cnt counts down to the adder's FINISH cycle: issue cycle + latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_cnt       <= '0;
            r_add_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_error <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_add_valid <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_op_a, r_op_b} <= r_mem[r_rd_ptr[c_aw-1:0]];
                        r_add_valid      <= 1'b1;
                        r_state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= w_exc ? c_cnt_exc : c_cnt_norm;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_out_sum   <= add_sum;
                        r_out_error <= add_error;
                        r_out_valid <= 1'b1;
                        if (add_error && (r_err_cnt != {ERRW{1'b1}})) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = !w_full;
    assign add_a     = r_op_a;
    assign add_b     = r_op_b;
    assign add_valid = r_add_valid;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_error = r_out_error;
    assign err_cnt   = r_err_cnt;
    assign busy      = (r_state != S_IDLE) || !w_empty || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_sequencer
// Purpose  : Self-checking bench for fp_add_sequencer with an fp_adder stand-in
//            and a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_sequencer;

    localparam int DEPTH    = 4;
    localparam int LAT_NORM = 4;
    localparam int LAT_EXC  = 2;
    localparam int ERRW     = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid, in_ready, add_valid, add_error;
    logic            out_valid, out_ready, out_error, busy;
    logic [31:0]     in_a, in_b, add_a, add_b, add_sum, out_sum;
    logic [ERRW-1:0] err_cnt;

    always #5 clk = ~clk;

    fp_add_sequencer #(.DEPTH(DEPTH), .LAT_NORM(LAT_NORM), .LAT_EXC(LAT_EXC), .ERRW(ERRW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
        .add_sum(add_sum), .add_error(add_error), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_error(out_error), .busy(busy), .err_cnt(err_cnt)
    );

    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    typedef struct { logic [31:0] sum; logic err; } res_t;

    pair_t src[$];
    pair_t pending[$];
    res_t  exp_res[$];
    int    lat_log[$];

    int checks = 0, failures = 0, cyc = 0;
    int exp_err = 0, n_issue = 0, n_deliver = 0;
    int iss_cyc = 0, iss_lat = 0, last_iss_cyc = 0, last_lat_obs = 0;
    int vprob = 100, rprob = 100;
    bit inflight = 0, have_last = 0, pushed_last = 0, was_valid = 0;
    logic [31:0] iss_a, iss_b, last_sum;
    logic        last_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_exc(input logic [31:0] x);
        return x[30:23] == 8'hFF;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return is_exc(x) && (x[22:0] != 23'd0);
    endfunction

    // Stand-in arithmetic: exact for the IEEE special cases exercised, arbitrary mix otherwise.
    function automatic res_t adder_model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r.err = 1'b0;
        if (is_nan(a) || is_nan(b) || (is_exc(a) && is_exc(b) && a[31] != b[31])) begin
            r.sum = 32'h7FFFFFFF;
            r.err = 1'b1;
        end else if (is_exc(a))                        r.sum = a;
        else if (is_exc(b))                            r.sum = b;
        else if (a == 32'h3F800000 && b == 32'h40000000) r.sum = 32'h40400000;
        else                                           r.sum = a + {b[15:0], b[31:16]};
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        int r;
        x = $urandom;
        r = $urandom_range(0, 7);
        if (r == 0)      x = {x[31], 8'hFF, 23'd0};
        else if (r == 1) x = {x[31], 8'hFF, x[22:0] | 23'h400000};
        else if (x[30:23] == 8'hFF) x[23] = 1'b0;
        return x;
    endfunction

    task automatic add_src(input logic [31:0] a, input logic [31:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        src.push_back(p);
    endtask

    task automatic step();
        res_t r;
        @(negedge clk);
        cyc++;
        if (add_valid) begin
            n_issue++;
            chk("issue_while_adder_busy", inflight, 0);
            if (have_last) chk("issue_spacing", (cyc - last_iss_cyc) >= (iss_lat + 2), 1);
            chk("issue_has_operands", pending.size() != 0, 1);
            if (pending.size() != 0) begin
                chk("issue_a", add_a, pending[0].a);
                chk("issue_b", add_b, pending[0].b);
                void'(pending.pop_front());
            end
            inflight = 1; iss_cyc = cyc; iss_a = add_a; iss_b = add_b;
            iss_lat = (is_exc(add_a) || is_exc(add_b)) ? LAT_EXC : LAT_NORM;
            last_iss_cyc = cyc; have_last = 1;
        end else if (inflight) begin
            chk("add_a_hold", add_a, iss_a);
            chk("add_b_hold", add_b, iss_b);
        end
        chk("out_valid", out_valid, exp_res.size() != 0);
        if (out_valid && exp_res.size() != 0) begin
            chk("out_sum", out_sum, exp_res[0].sum);
            chk("out_error", out_error, exp_res[0].err);
        end
        if (out_valid && !was_valid) begin
            last_lat_obs = cyc - last_iss_cyc;
            lat_log.push_back(last_lat_obs);
        end
        was_valid = out_valid;
        chk("in_ready", in_ready, pending.size() < DEPTH);
        chk("err_cnt", err_cnt, exp_err);
        chk("busy", busy, (pending.size() != 0) || inflight || (exp_res.size() != 0));
        // Adder stand-in: the sum is only meaningful in the FINISH cycle.
        if (inflight && cyc == iss_cyc + iss_lat) begin
            r = adder_model(iss_a, iss_b);
            add_sum = r.sum;
            add_error = r.err;
            exp_res.push_back(r);
            if (r.err && exp_err < (2 ** ERRW - 1)) exp_err++;
            inflight = 0;
        end else begin
            add_sum = $urandom;
            add_error = 1'($urandom_range(0, 1));
        end
        if (pushed_last) in_valid = 1'b0;
        if (!in_valid && src.size() != 0 && $urandom_range(1, 100) <= vprob) begin
            in_valid = 1'b1;
            in_a = src[0].a;
            in_b = src[0].b;
        end
        pushed_last = in_valid && in_ready;
        if (pushed_last) begin
            pending.push_back(src[0]);
            void'(src.pop_front());
        end
        out_ready = ($urandom_range(1, 100) <= rprob);
        if (out_valid && out_ready && exp_res.size() != 0) begin
            last_sum = out_sum;
            last_err = out_error;
            n_deliver++;
            void'(exp_res.pop_front());
        end
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((src.size() != 0 || pending.size() != 0 || inflight || exp_res.size() != 0 || in_valid)
               && k < maxc) begin
            step();
            k++;
        end
        chk("drain_timeout", k < maxc, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, d0, k;
        in_valid = 0; in_a = 0; in_b = 0; out_ready = 0; add_sum = 0; add_error = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_add_valid", add_valid, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        repeat (2) step();

        // Normal add 1.0 + 2.0
        n0 = n_issue; vprob = 100; rprob = 100;
        add_src(32'h3F800000, 32'h40000000);
        drain(100);
        chk("t1_issue_count", n_issue - n0, 1);
        chk("t1_latency", last_lat_obs, LAT_NORM + 1);
        chk("t1_sum", last_sum, 32'h40400000);
        chk("t1_error", last_err, 0);
        chk("t1_err_cnt", err_cnt, 0);

        // Infinity path
        add_src(32'h7F800000, 32'h3F800000);
        drain(100);
        chk("t2_latency", last_lat_obs, 3);
        chk("t2_sum", last_sum, 32'h7F800000);
        chk("t2_error", last_err, 0);

        // NaN path
        add_src(32'h7FC00000, 32'h3F800000);
        drain(100);
        chk("t3_latency", last_lat_obs, 3);
        chk("t3_sum", last_sum, 32'h7FFFFFFF);
        chk("t3_error", last_err, 1);
        chk("t3_err_cnt", err_cnt, 1);

        // Back-pressure with a full FIFO
        n0 = n_issue; d0 = n_deliver; rprob = 0;
        for (int i = 0; i < 6; i++) add_src(32'h3F800000 + i, 32'h40000000 + 32'(i * 3));
        repeat (30) step();
        chk("t4_in_ready_low", in_ready, 0);
        chk("t4_result_held", out_valid, 1);
        chk("t4_single_issue", n_issue - n0, 1);
        chk("t4_pair6_waiting", src.size(), 1);
        rprob = 100;
        drain(300);
        chk("t4_delivered", n_deliver - d0, 6);

        // Mixed latencies
        lat_log.delete();
        add_src(32'h40800000, 32'h3F800000);
        add_src(32'hFF800000, 32'h3F800000);
        add_src(32'h41000000, 32'hC0000000);
        drain(200);
        chk("t5_count", lat_log.size(), 3);
        if (lat_log.size() == 3) begin
            chk("t5_lat0", lat_log[0], 5);
            chk("t5_lat1", lat_log[1], 3);
            chk("t5_lat2", lat_log[2], 5);
        end

        // Randomised traffic
        d0 = n_deliver;
        for (int i = 0; i < 200; i++) add_src(rand_op(), rand_op());
        k = 0;
        while ((src.size() != 0 || pending.size() != 0 || inflight || exp_res.size() != 0 || in_valid)
               && k < 20000) begin
            if (k % 40 == 0) begin
                vprob = $urandom_range(20, 100);
                rprob = $urandom_range(10, 100);
            end
            step();
            k++;
        end
        chk("rand_timeout", k < 20000, 1);
        chk("rand_delivered", n_deliver - d0, 200);

        // Reset two cycles after an issue
        vprob = 100; rprob = 100; n0 = n_issue; d0 = n_deliver;
        add_src(32'h3F800000, 32'h40000000);
        add_src(32'h40400000, 32'h40400000);
        k = 0;
        while (n_issue == n0 && k < 20) begin step(); k++; end
        chk("t6_issue_seen", n_issue - n0, 1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_add_valid", add_valid, 0);
        chk("t6_err_cnt", err_cnt, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_busy", busy, 0);
        src.delete(); pending.delete(); exp_res.delete();
        inflight = 0; have_last = 0; pushed_last = 0; was_valid = 0; exp_err = 0;
        in_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("t6_no_stale_result", n_deliver - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
